// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) sequencer: steps a WIDTH-bit ring a programmed number of times
// per command, with pause/abort, direction select, phase decode and illegal-state recovery.
//
// state | meaning
// IDLE  | waiting for start; count holds
// RUN   | stepping once per cycle until remaining reaches zero
// PAUSE | run suspended, count holds
// DONE  | one-cycle completion pulse
module johnson_seq_ctrl #(
  parameter  int WIDTH = 4,
  parameter  int CW    = 8,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    load_cycles,
  input  logic             dir,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [PW:0] PH_RING = (PW+1)'(2*WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [CW-1:0]    r_remaining;
  logic             r_dir;
  logic             r_err;

  logic [PW-1:0]    w_ones;
  logic [PW-1:0]    w_edges;
  logic [PW:0]      w_wrap;
  logic [PW-1:0]    w_phase;
  logic             w_illegal;
  logic             w_step;
  logic             w_accept;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_rev;

  // A legal Johnson word has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    w_ones  = '0;
    w_edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + PW'(r_count[i]);
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      w_edges = w_edges + PW'(r_count[i] ^ r_count[i+1]);
    end
    w_illegal = (w_edges > PW'(1));
  end

  always_comb begin
    w_wrap = PH_RING - {1'b0, w_ones};
    if (r_count[WIDTH-1]) begin
      w_phase = w_ones;
    end else if (w_ones == '0) begin
      w_phase = '0;
    end else begin
      w_phase = w_wrap[PW-1:0];
    end
  end

  assign w_fwd    = {~r_count[0], r_count[WIDTH-1:1]};
  assign w_rev    = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
  assign w_step   = (r_state == S_RUN) && !pause && !abort && !w_illegal;
  assign w_accept = (r_state == S_IDLE) && start && !w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (load_cycles == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else if (r_remaining == CW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (!pause) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_illegal) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_illegal) begin
      r_count     <= '0;
      r_remaining <= '0;
      r_err       <= 1'b1;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_dir       <= dir;
        r_remaining <= load_cycles;
      end
      if (w_step) begin
        r_count     <= r_dir ? w_rev : w_fwd;
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

  always_comb begin
    busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
    done  = (r_state == S_DONE);
    err   = r_err;
    count = r_count;
    phase = w_phase;
  end

endmodule
